// File: rtl/lattice_result_arbiter.sv
// Two-stage compact-target compare across LANES hash lanes, feeding a hit queue of processor indices.
// Build macro LATTICE_HIT_QUEUE_EN selects a FIFO_DEPTH-entry queue; without it a single holding register is used.
module lattice_result_arbiter #(
    parameter int LANES      = 4,
    parameter int BASE_INDEX = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     hash_valid,
    input  logic                 hash_new,
    input  logic [LANES*256-1:0] hash,
    input  logic [31:0]          difficulty,
    output logic                 valid_o,
    output logic                 newblock_o,
    output logic                 success,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDX_W-1:0]     res_index,
    output logic                 overflow
);

    logic [7:0]   w_exp;
    logic [23:0]  w_mant;
    logic [7:0]   w_shl;
    logic [7:0]   w_shr;
    logic [255:0] w_target;

    assign w_exp  = difficulty[31:24];
    assign w_mant = difficulty[23:0];
    assign w_shl  = (w_exp - 8'd3) << 3;
    assign w_shr  = (8'd3 - w_exp) << 3;

    always_comb begin
        w_target = {232'd0, w_mant};
        if (w_exp > 8'd34) begin
            w_target = '1;
        end else if (w_exp >= 8'd3) begin
            w_target = {232'd0, w_mant} << w_shl;
        end else begin
            w_target = {232'd0, w_mant} >> w_shr;
        end
    end

    logic [LANES*256-1:0] r_s1_hash;
    logic [255:0]         r_s1_target;
    logic [LANES-1:0]     r_s1_valid;
    logic                 r_s1_new;
    logic [LANES-1:0]     w_hit;
    logic [LANES-1:0]     r_s2_hit;
    logic                 r_s2_valid;
    logic                 r_s2_new;

    // Data registers need no reset: nothing downstream looks at them without a valid bit.
    always_ff @(posedge clk) begin
        r_s1_hash   <= hash;
        r_s1_target <= w_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= '0;
            r_s1_new   <= 1'b0;
        end else begin
            r_s1_valid <= hash_valid;
            r_s1_new   <= hash_new;
        end
    end

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < LANES; k++) begin
            w_hit[k] = r_s1_valid[k] && (r_s1_hash[256*k +: 256] <= r_s1_target);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_hit   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_new   <= 1'b0;
        end else begin
            r_s2_hit   <= w_hit;
            r_s2_valid <= |r_s1_valid;
            r_s2_new   <= r_s1_new;
        end
    end

    assign valid_o    = r_s2_valid;
    assign newblock_o = r_s2_new;
    assign success    = |r_s2_hit;

    logic w_pop;
    logic w_flush;
    logic w_ovf_set;
    logic r_overflow;

    assign w_pop    = res_valid && res_ready;
    assign w_flush  = r_s2_new;
    assign overflow = r_overflow;

`ifdef LATTICE_HIT_QUEUE_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [IDX_W-1:0] r_mem     [FIFO_DEPTH];
    logic [IDX_W-1:0] w_mem_nxt [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Pop and flush free space first, so a full queue can take a push on the popping cycle.
    always_comb begin
        w_mem_nxt = r_mem;
        w_ovf_set = 1'b0;
        if (w_flush) begin
            w_rd_nxt  = '0;
            w_wr_nxt  = '0;
            w_cnt_nxt = '0;
        end else begin
            w_rd_nxt  = r_rd_ptr + PTR_W'(w_pop);
            w_wr_nxt  = r_wr_ptr;
            w_cnt_nxt = r_count - CNT_W'(w_pop);
        end
        for (int k = 0; k < LANES; k++) begin
            if (r_s2_hit[k]) begin
                if (w_cnt_nxt < CNT_W'(FIFO_DEPTH)) begin
                    w_mem_nxt[w_wr_nxt] = IDX_W'(BASE_INDEX + k);
                    w_wr_nxt            = w_wr_nxt + 1'b1;
                    w_cnt_nxt           = w_cnt_nxt + 1'b1;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_mem      <= w_mem_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_count    <= w_cnt_nxt;
            r_overflow <= (r_overflow && !w_flush) || w_ovf_set;
        end
    end

    assign res_valid = (r_count != '0);
    assign res_index = r_mem[r_rd_ptr];
`else
    logic             r_hold_valid;
    logic [IDX_W-1:0] r_hold_idx;
    logic             w_free;
    logic             w_found;
    logic [IDX_W-1:0] w_cap_idx;
    logic             w_depth_unused;

    // The queue depth only sizes the queued build.
    assign w_depth_unused = (FIFO_DEPTH > 1);

    always_comb begin
        w_free    = !r_hold_valid || w_pop || w_flush;
        w_found   = 1'b0;
        w_cap_idx = r_hold_idx;
        w_ovf_set = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (r_s2_hit[k]) begin
                if (w_free && !w_found) begin
                    w_found   = 1'b1;
                    w_cap_idx = IDX_W'(BASE_INDEX + k);
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_idx   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_hold_valid <= w_found || (r_hold_valid && !w_pop && !w_flush);
            r_hold_idx   <= w_cap_idx;
            r_overflow   <= (r_overflow && !w_flush) || w_ovf_set;
        end
    end

    assign res_valid = r_hold_valid;
    assign res_index = r_hold_idx;
`endif

endmodule

// File: tb/tb_lattice_result_arbiter.sv
// Bench for lattice_result_arbiter: directed scenarios then random beats, all checked against a queue-level reference model.
module tb_lattice_result_arbiter;

    localparam int LANES = 4;
    localparam int BASE  = 5;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [LANES-1:0]     hash_valid;
    logic                 hash_new;
    logic [LANES*256-1:0] hash;
    logic [31:0]          difficulty;
    logic                 valid_o;
    logic                 newblock_o;
    logic                 success;
    logic                 res_valid;
    logic                 res_ready;
    logic [IDX_W-1:0]     res_index;
    logic                 overflow;

    always #5 clk = ~clk;

    lattice_result_arbiter #(
        .LANES(LANES), .BASE_INDEX(BASE), .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .hash_valid(hash_valid), .hash_new(hash_new),
        .hash(hash), .difficulty(difficulty), .valid_o(valid_o),
        .newblock_o(newblock_o), .success(success), .res_valid(res_valid),
        .res_ready(res_ready), .res_index(res_index), .overflow(overflow)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             v;
        logic             nb;
        logic [LANES-1:0] hits;
    } beat_t;

    beat_t m_s1;
    beat_t m_s2;
    int    mq[$];
    logic  m_ovf;

    function automatic logic [255:0] tgt(logic [31:0] d);
        int           e = int'(d[31:24]);
        logic [255:0] m = {232'd0, d[23:0]};
        if (e > 34) return '1;
        if (e >= 3) return m << (8 * (e - 3));
        return m >> (8 * (3 - e));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        beat_t cur;
        bit    pop;
        bit    taken;
        cur.v  = |hash_valid;
        cur.nb = hash_new;
        for (int k = 0; k < LANES; k++) begin
            cur.hits[k] = hash_valid[k] && (hash[256*k +: 256] <= tgt(difficulty));
        end
        pop = (mq.size() > 0) && res_ready;
        @(posedge clk);
        if (rst) begin
            m_s1  = '{v: 1'b0, nb: 1'b0, hits: '0};
            m_s2  = '{v: 1'b0, nb: 1'b0, hits: '0};
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_s2.nb) begin
                mq.delete();
                m_ovf = 1'b0;
            end
            taken = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                if (m_s2.hits[k]) begin
`ifdef LATTICE_HIT_QUEUE_EN
                    if (mq.size() < DEPTH) mq.push_back(BASE + k);
                    else m_ovf = 1'b1;
`else
                    if (!taken && mq.size() == 0) begin
                        mq.push_back(BASE + k);
                        taken = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
`endif
                end
            end
            m_s2 = m_s1;
            m_s1 = cur;
        end
        @(negedge clk);
        chk("valid_o", 32'(valid_o), 32'(m_s2.v));
        chk("newblock_o", 32'(newblock_o), 32'(m_s2.nb));
        chk("success", 32'(success), 32'(|m_s2.hits));
        chk("res_valid", 32'(res_valid), 32'(mq.size() > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) chk("res_index", 32'(res_index), 32'(mq[0]));
    endtask

    task automatic idle();
        hash_valid = '0;
        hash_new   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    logic [255:0] t;

    initial begin
        m_s1  = '{v: 1'b0, nb: 1'b0, hits: '0};
        m_s2  = '{v: 1'b0, nb: 1'b0, hits: '0};
        m_ovf = 1'b0;
        rst = 1'b1; hash = '0; difficulty = '0; res_ready = 1'b0;
        idle();
        step();
        step();
        chk("rst_res_index", 32'(res_index), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;

        // single hit on lane 2: success at cycle 2, result at cycle 3
        difficulty = 32'h1d00ffff;
        res_ready  = 1'b1;
        hash       = {LANES{256'h1}};
        hash[2*256 +: 256] = '0;
        hash_valid = 4'b0100;
        step();
        idle();
        step();
        chk("lat_valid_o", 32'(valid_o), 32'd1);
        chk("lat_success", 32'(success), 32'd1);
        step();
        chk("lat_res_valid", 32'(res_valid), 32'd1);
        chk("lat_res_index", 32'(res_index), 32'(BASE + 2));
        step();
        step();

        // exponent below 3: target 0xff, 0xff hits and 0x100 misses
        do_reset();
        difficulty = {8'h02, 24'h00ff00};
        res_ready  = 1'b0;
        hash[0 +: 256]   = 256'hff;
        hash[256 +: 256] = 256'h100;
        hash_valid = 4'b0011;
        step();
        idle();
        step();
        chk("small_e_success", 32'(success), 32'd1);
        step();
        chk("small_e_index", 32'(res_index), 32'(BASE));
        res_ready = 1'b1;
        step();
        chk("small_e_one_hit", 32'(res_valid), 32'd0);
        chk("small_e_no_ovf", 32'(overflow), 32'd0);

        // lanes 1 and 3 hit on one beat
        do_reset();
        difficulty = 32'h1d00ffff;
        res_ready  = 1'b0;
        hash = {LANES{256'hffff}};
        hash[256 +: 256]   = '0;
        hash[3*256 +: 256] = '0;
        hash_valid = 4'b1010;
        step();
        idle();
        step();
        step();
        chk("two_hit_index", 32'(res_index), 32'(BASE + 1));
`ifdef LATTICE_HIT_QUEUE_EN
        chk("two_hit_ovf", 32'(overflow), 32'd0);
`else
        chk("two_hit_ovf", 32'(overflow), 32'd1);
`endif
        res_ready = 1'b1;
        step();
`ifdef LATTICE_HIT_QUEUE_EN
        chk("two_hit_second", 32'(res_index), 32'(BASE + 3));
`else
        chk("two_hit_drained", 32'(res_valid), 32'd0);
`endif
        step();

        // all four lanes hit, consumer stalled 6 cycles
        do_reset();
        res_ready  = 1'b0;
        hash       = '0;
        hash_valid = 4'b1111;
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        res_ready = 1'b1;
        chk("drain_0", 32'(res_index), 32'(BASE));
        step();
`ifdef LATTICE_HIT_QUEUE_EN
        chk("drain_1", 32'(res_index), 32'(BASE + 1));
        step();
        chk("drain_2", 32'(res_index), 32'(BASE + 2));
        step();
        chk("drain_3", 32'(res_index), 32'(BASE + 3));
        chk("drain_ovf", 32'(overflow), 32'd0);
        step();
`else
        chk("drain_ovf", 32'(overflow), 32'd1);
`endif
        chk("drain_empty", 32'(res_valid), 32'd0);

        // five hits into a stalled queue, then a new block flushes
        do_reset();
        res_ready  = 1'b0;
        hash       = '0;
        hash_valid = 4'b1111;
        step();
        hash_valid = 4'b0001;
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_valid", 32'(res_valid), 32'd1);
        chk("full_head", 32'(res_index), 32'(BASE));
        hash_new = 1'b1;
        step();
        idle();
        step();
        step();
        chk("flush_valid", 32'(res_valid), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd0);

        // reset one cycle after a hitting beat discards it
        do_reset();
        res_ready  = 1'b1;
        hash       = '0;
        hash_valid = 4'b0001;
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid_success", 32'(success), 32'd0);
            chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
            chk("rst_mid_valid_o", 32'(valid_o), 32'd0);
        end

        // randomized beats against the reference model
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            hash_new   = ($urandom_range(0, 15) == 0);
            hash_valid = LANES'($urandom);
            res_ready  = $urandom_range(0, 1) == 1;
            difficulty = {8'($urandom_range(0, 36)), 24'($urandom)};
            t = tgt(difficulty);
            for (int k = 0; k < LANES; k++) begin
                case ($urandom_range(0, 4))
                    0: hash[256*k +: 256] = '0;
                    1: hash[256*k +: 256] = t;
                    2: hash[256*k +: 256] = t + 256'd1;
                    3: hash[256*k +: 256] = rand256();
                    default: hash[256*k +: 256] = t >> 1;
                endcase
            end
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
